// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock, signs
// applied in a final fix-up cycle, single-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for i_start
// RUN   | WIDTH shift/trial-subtract iterations
// FIX   | apply signs, divide-by-zero override, register results
// DONE  | o_done pulse; may accept the next start
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_dz
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] op1_q;
  logic             q_neg;
  logic             r_neg;

  logic             start_ok;
  logic             op1_negative;
  logic             op2_negative;
  logic [WIDTH-1:0] op1_abs;
  logic [WIDTH-1:0] op2_abs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             dz;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  assign start_ok     = i_start && ((state == S_IDLE) || (state == S_DONE));
  assign op1_negative = i_signed && i_op1[WIDTH-1];
  assign op2_negative = i_signed && i_op2[WIDTH-1];
  assign op1_abs      = op1_negative ? (~i_op1 + 1'b1) : i_op1;
  assign op2_abs      = op2_negative ? (~i_op2 + 1'b1) : i_op2;

  // Partial remainder stays below the divisor, so WIDTH bits suffice between
  // iterations; the trial subtraction itself is WIDTH+1 bits wide.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dsr_q};

  assign dz       = (dsr_q == '0);
  assign quot_fix = q_neg ? (~dvd_q + 1'b1) : dvd_q;
  assign rem_fix  = r_neg ? (~rem_q + 1'b1) : rem_q;

  assign o_busy = (state == S_RUN) || (state == S_FIX);
  assign o_done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_start) state_nxt = S_RUN;
      S_RUN:  if (cnt == LAST) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = i_start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      dsr_q  <= '0;
      op1_q  <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      o_quot <= '0;
      o_rem  <= '0;
      o_dz   <= 1'b0;
    end else if (start_ok) begin
      cnt    <= '0;
      rem_q  <= '0;
      dvd_q  <= op1_abs;
      dsr_q  <= op2_abs;
      op1_q  <= i_op1;
      q_neg  <= op1_negative ^ op2_negative;
      r_neg  <= op1_negative;
    end else begin
      case (state)
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (!diff[WIDTH]) begin
            rem_q <= diff[WIDTH-1:0];
          end else begin
            rem_q <= shifted[WIDTH-1:0];
          end
          dvd_q <= {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
        end
        S_FIX: begin
          // Zero divisor reports all-ones quotient and the raw dividend in
          // both modes; unsigned already gets this from the loop.
          if (dz) begin
            o_quot <= '1;
            o_rem  <= op1_q;
          end else begin
            o_quot <= quot_fix;
            o_rem  <= rem_fix;
          end
          o_dz <= dz;
        end
        default: ;
      endcase
    end
  end

endmodule
